avalon_st_packet_enforcer: RTL and testbench
============================================

# avalon_st_packet_enforcer

Registered Avalon-ST stage placed directly downstream of any `avalon_st_if` master and upstream of the consuming slave in the avalon_enforcer datapath. It enforces packet framing on the stream:
- beats outside a packet are discarded;
- stray start-of-packet markers inside a packet are masked;
- packets longer than a configured limit are truncated with a forced end-of-packet.

Every violation raises a one-cycle error pulse.

## Interface
Parameters:
- DATA_WIDTH_IN_BYTES, 16, byte width of both stream interfaces; empty width is log2up_func(DATA_WIDTH_IN_BYTES).
- MAX_PACKET_BEATS, 64, maximum beats per packet, including the sop and eop beats; legal range ≥ 2.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- msg_in  avalon_st_if.slave  DATA_WIDTH_IN_BYTES  upstream stream (data, valid, rdy, sop, eop, empty).
- msg_out  avalon_st_if.master  DATA_WIDTH_IN_BYTES  downstream stream.
- err_no_sop  output  1  pulse: beat accepted while no packet was open and the beat had sop=0; beat dropped.
- err_extra_sop  output  1  pulse: sop=1 beat accepted while a packet was open; sop masked.
- err_oversize  output  1  pulse: packet truncated at MAX_PACKET_BEATS.

## Operation
- An input beat is *accepted* when msg_in.valid & msg_in.rdy.
- msg_in.rdy = !rst & (!msg_out.valid | msg_out.rdy). This is combinational; ready is never withdrawn because of an input decision.
- Beat counter cnt has width log2up_func(MAX_PACKET_BEATS+1) and counts forwarded beats of the current packet.
- FSM states: IDLE, IN_PACKET, DISCARD. Reset state is IDLE. Only accepted beats change state.
- IDLE:
  - sop=1, eop=1: forward; stay IDLE; cnt=0.
  - sop=1, eop=0: forward; cnt=1; go to IN_PACKET.
  - sop=0: drop the beat; pulse err_no_sop; stay IDLE.
- IN_PACKET:
  - Every beat is forwarded.
  - sop=1: output sop forced 0; pulse err_extra_sop.
  - eop=1: forward with eop=1 and empty passed through; go to IDLE; cnt=0.
  - eop=0 and cnt+1 = MAX_PACKET_BEATS: forward with eop forced 1 and empty forced 0; pulse err_oversize; go to DISCARD.
  - Otherwise: cnt++.
  - When the final beat carries both sop=1 and eop=1, or both sop=1 and an oversize truncation, both corresponding pulses fire in the same cycle.
- DISCARD:
  - sop=0 beats are dropped silently (no error pulse).
  - sop=0, eop=1: drop the beat; go to IDLE.
  - sop=1: handled exactly as in IDLE (new packet starts; no error pulse).
- Output fields:
  - On every forwarded beat that is not an eop beat, empty is driven 0.
  - data is forwarded unchanged.
  - Dropped beats never load the output register.

## Timing
- Output register stage: a forwarded beat appears on msg_out exactly 1 cycle after acceptance.
- Throughput is 1 beat/cycle when msg_out.rdy is held high.
- Output register load/hold:
  - It loads on any forwarded acceptance.
  - It clears valid when msg_out.rdy=1 and there is no new forwarded beat.
  - It holds all fields stable while msg_out.valid & !msg_out.rdy.
- err_* outputs are registered and assert in the cycle after the offending acceptance, for exactly 1 cycle.
- Reset (asynchronous, at any time including mid-packet):
  - msg_out.valid/sop/eop = 0, msg_out.data = 0, msg_out.empty = 0.
  - err_* = 0, state = IDLE, cnt = 0, msg_in.rdy = 0.
  - A partially sent packet is abandoned; after reset release, the first beat must carry sop.
- Backpressure: when msg_out.valid=1 and msg_out.rdy=0, msg_in.rdy=0. Even a beat that would be dropped is not accepted, so drop decisions are always made at acceptance.
- The counter cannot wrap: cnt saturates by construction because the FSM leaves IN_PACKET at MAX_PACKET_BEATS.

## Test plan
- Clean traffic: 3-beat packet, data 0x1..0x3, last beat empty=5, msg_out.rdy=1 → identical beats on msg_out, each 1 cycle after input; empty=5 on beat 3 only; no error pulses.
- Orphan beats: two sop=0 beats sent before a 1-beat packet (sop=eop=1) → both dropped; err_no_sop pulses twice; only the single-beat packet appears at the output.
- Extra sop: 4-beat packet with sop=1 also on beat 3 → 4 beats out; sop=1 only on beat 1; one err_extra_sop pulse, 1 cycle after beat 3 is accepted.
- Oversize (MAX_PACKET_BEATS=4): 7-beat packet → 4 beats out, beat 4 has eop=1 and empty=0; err_oversize pulses once; beats 5–7 dropped; the next sop packet passes cleanly.
- Backpressure: msg_out.rdy toggled 1,0,0,1 during a 3-beat packet → msg_in.rdy low while stalled; output fields stable during the stall; no beat lost or duplicated.
- Reset mid-packet: rst asserted after beat 2 of 5 → outputs and rdy zero immediately; after release, a sop=0 beat is dropped with err_no_sop.

Source files
------------

// File: rtl/avalon_st_packet_enforcer_if.sv
// Avalon-ST stream bundle: data, valid, rdy, sop, eop, empty.
// Latency: none, this is a plain signal bundle.
// Backpressure: rdy is driven by the slave side and flows back to the master.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    // log2up: ceil(log2(n)) with a floor of 1 bit.
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;

    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_packet_enforcer.sv
// Packet framing enforcer: drops orphan beats, masks stray sop, truncates oversize packets.
// Latency: 1 cycle through the output register; error pulses are also 1 cycle after acceptance.
// Backpressure: msg_in.rdy = !rst & (!msg_out.valid | msg_out.rdy); stalled output holds all fields.
module avalon_st_packet_enforcer #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_PACKET_BEATS    = 64
) (
    input  logic       clk,
    input  logic       rst,
    avalon_st_if.slave  msg_in,
    avalon_st_if.master msg_out,
    output logic       err_no_sop,
    output logic       err_extra_sop,
    output logic       err_oversize
);
    localparam int DW      = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
    localparam int CNT_W   = $clog2(MAX_PACKET_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PACKET_BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, IN_PACKET, DISCARD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               r_vld;
    logic               r_sop;
    logic               r_eop;
    logic [DW-1:0]      r_data;
    logic [EMPTY_W-1:0] r_empty;

    logic               r_err_no_sop;
    logic               r_err_extra_sop;
    logic               r_err_oversize;

    logic               w_rdy;
    logic               w_accept;
    logic               w_fwd;
    logic               w_sop;
    logic               w_eop;
    logic [EMPTY_W-1:0] w_empty;
    logic               w_e_no_sop;
    logic               w_e_extra_sop;
    logic               w_e_oversize;

    // Ready depends only on the output register, so every drop decision is made at acceptance.
    assign w_rdy      = !rst && (!r_vld || msg_out.rdy);
    assign w_accept   = msg_in.valid && w_rdy;
    assign msg_in.rdy = w_rdy;

    assign msg_out.valid = r_vld;
    assign msg_out.sop   = r_sop;
    assign msg_out.eop   = r_eop;
    assign msg_out.data  = r_data;
    assign msg_out.empty = r_empty;

    assign err_no_sop    = r_err_no_sop;
    assign err_extra_sop = r_err_extra_sop;
    assign err_oversize  = r_err_oversize;

    // Framing state and beat count advance only on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Decide forward/drop, the rewritten sop/eop/empty and the error flags for the current beat.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_fwd         = 1'b0;
        w_sop         = 1'b0;
        w_eop         = 1'b0;
        w_empty       = '0;
        w_e_no_sop    = 1'b0;
        w_e_extra_sop = 1'b0;
        w_e_oversize  = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE, DISCARD: begin
                    if (msg_in.sop) begin
                        w_fwd   = 1'b1;
                        w_sop   = 1'b1;
                        w_eop   = msg_in.eop;
                        w_empty = msg_in.eop ? msg_in.empty : '0;
                        if (msg_in.eop) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = IN_PACKET;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end else if (r_state == IDLE) begin
                        w_e_no_sop = 1'b1;
                    end else if (msg_in.eop) begin
                        // Tail of a truncated packet ends quietly.
                        w_state_nxt = IDLE;
                    end
                end
                IN_PACKET: begin
                    w_fwd         = 1'b1;
                    w_e_extra_sop = msg_in.sop;
                    if (msg_in.eop) begin
                        w_eop       = 1'b1;
                        w_empty     = msg_in.empty;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt + CNT_ONE == CNT_MAX) begin
                        // Limit reached: close the packet here and swallow the rest of it.
                        w_eop        = 1'b1;
                        w_e_oversize = 1'b1;
                        w_state_nxt  = DISCARD;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output register: load forwarded beats, clear valid once consumed, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_data  <= '0;
            r_empty <= '0;
        end else if (w_fwd) begin
            r_vld   <= 1'b1;
            r_sop   <= w_sop;
            r_eop   <= w_eop;
            r_data  <= msg_in.data;
            r_empty <= w_empty;
        end else if (msg_out.rdy) begin
            r_vld   <= 1'b0;
        end
    end

    // Error pulses are registered so each lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_no_sop    <= 1'b0;
            r_err_extra_sop <= 1'b0;
            r_err_oversize  <= 1'b0;
        end else begin
            r_err_no_sop    <= w_e_no_sop;
            r_err_extra_sop <= w_e_extra_sop;
            r_err_oversize  <= w_e_oversize;
        end
    end
endmodule

// File: tb/tb_avalon_st_packet_enforcer.sv
// Scoreboard bench for avalon_st_packet_enforcer with MAX_PACKET_BEATS=4.
// Driver pushes expected beats/error pulses at acceptance; a negedge monitor pops and compares.
// Backpressure, stall stability and mid-packet reset are exercised with directed vectors.
module tb_avalon_st_packet_enforcer;
    localparam int W    = 16;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_no_sop, err_extra_sop, err_oversize;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) in_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) out_if ();

    avalon_st_packet_enforcer #(
        .DATA_WIDTH_IN_BYTES(W),
        .MAX_PACKET_BEATS   (MAXB)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .msg_in       (in_if),
        .msg_out      (out_if),
        .err_no_sop   (err_no_sop),
        .err_extra_sop(err_extra_sop),
        .err_oversize (err_oversize)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   empty;
        time          t;
    } beat_t;

    beat_t      exp_q[$];
    logic [2:0] err_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one beat (called just after a posedge); returns just after the accepting posedge.
    // xerr = {no_sop, extra_sop, oversize} expected in the cycle after acceptance.
    task automatic send(input logic [127:0] d, input logic s, input logic e, input logic [3:0] em,
                        input logic fwd, input logic xs, input logic xe, input logic [3:0] xem,
                        input logic [2:0] xerr);
        logic  ok;
        beat_t b;
        in_if.data  = d;
        in_if.sop   = s;
        in_if.eop   = e;
        in_if.empty = em;
        in_if.valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_if.rdy;
            @(posedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 128'(0), 128'(1));
        end else begin
            if (fwd) begin
                b.data = d; b.sop = xs; b.eop = xe; b.empty = xem; b.t = $time;
                exp_q.push_back(b);
            end
            err_q.push_back(xerr);
        end
        #1;
    endtask

    task automatic idle();
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_rdy"}, 128'(in_if.rdy), 128'(0));
        chk({tag, "_valid"}, 128'(out_if.valid), 128'(0));
        chk({tag, "_sop_eop"}, 128'({out_if.sop, out_if.eop}), 128'(0));
        chk({tag, "_data"}, out_if.data, 128'(0));
        chk({tag, "_empty"}, 128'(out_if.empty), 128'(0));
        chk({tag, "_err"}, 128'({err_no_sop, err_extra_sop, err_oversize}), 128'(0));
    endtask

    // Monitor state
    logic         prev_stall = 1'b0;
    logic [127:0] p_data;
    logic         p_sop, p_eop;
    logic [3:0]   p_empty;
    logic [2:0]   exp_err;
    beat_t        got;

    // Monitor: error pulses, stall behaviour, latency and beat contents.
    always @(negedge clk) begin
        exp_err = (err_q.size() > 0) ? err_q.pop_front() : 3'b000;
        chk("err_pulses", 128'({err_no_sop, err_extra_sop, err_oversize}), 128'(exp_err));
        if (out_if.valid && !out_if.rdy)
            chk("stall_in_rdy", 128'(in_if.rdy), 128'(0));
        if (prev_stall) begin
            chk("hold_data", out_if.data, p_data);
            chk("hold_ctl", 128'({out_if.sop, out_if.eop, out_if.empty}), 128'({p_sop, p_eop, p_empty}));
        end
        if (out_if.valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", out_if.data, 128'(0));
            end else begin
                if (!prev_stall)
                    chk("latency", 128'($time - exp_q[0].t), 128'(5));
                if (out_if.rdy) begin
                    got = exp_q.pop_front();
                    chk("beat_data", out_if.data, got.data);
                    chk("beat_sop", 128'(out_if.sop), 128'(got.sop));
                    chk("beat_eop", 128'(out_if.eop), 128'(got.eop));
                    chk("beat_empty", 128'(out_if.empty), 128'(got.empty));
                end
            end
        end
        prev_stall = out_if.valid && !out_if.rdy;
        p_data     = out_if.data;
        p_sop      = out_if.sop;
        p_eop      = out_if.eop;
        p_empty    = out_if.empty;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        in_if.data  = '0;
        in_if.empty = '0;
        out_if.rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst_init");
        rst = 1'b0;

        // Clean 3-beat packet
        send(128'h1, 1, 0, 0, 1, 1, 0, 0, 3'b000);
        send(128'h2, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        send(128'h3, 0, 1, 5, 1, 0, 1, 5, 3'b000);
        idle();

        // Orphan beats before a single-beat packet
        send(128'h11, 0, 0, 0, 0, 0, 0, 0, 3'b100);
        send(128'h12, 0, 1, 3, 0, 0, 0, 0, 3'b100);
        send(128'h13, 1, 1, 2, 1, 1, 1, 2, 3'b000);
        idle();

        // Stray sop on beat 3; non-eop empty forced to 0
        send(128'h21, 1, 0, 7, 1, 1, 0, 0, 3'b000);
        send(128'h22, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        send(128'h23, 1, 0, 0, 1, 0, 0, 0, 3'b010);
        send(128'h24, 0, 1, 3, 1, 0, 1, 3, 3'b000);
        idle();

        // 7-beat packet truncated at 4 (beat 4 also has a stray sop), tail dropped
        send(128'h31, 1, 0, 0, 1, 1, 0, 0, 3'b000);
        send(128'h32, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        send(128'h33, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        send(128'h34, 1, 0, 6, 1, 0, 1, 0, 3'b011);
        send(128'h35, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        send(128'h36, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        send(128'h37, 0, 1, 0, 0, 0, 0, 0, 3'b000);
        send(128'h38, 1, 1, 1, 1, 1, 1, 1, 3'b000);
        idle();

        // Truncation, then a new sop arrives while still discarding
        send(128'h41, 1, 0, 0, 1, 1, 0, 0, 3'b000);
        send(128'h42, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        send(128'h43, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        send(128'h44, 0, 0, 9, 1, 0, 1, 0, 3'b001);
        send(128'h45, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        send(128'h46, 1, 0, 0, 1, 1, 0, 0, 3'b000);
        send(128'h47, 0, 1, 4, 1, 0, 1, 4, 3'b000);
        idle();

        // Backpressure: downstream ready 1,0,0,1 across a 3-beat packet
        fork
            begin
                send(128'h51, 1, 0, 0, 1, 1, 0, 0, 3'b000);
                send(128'h52, 0, 0, 0, 1, 0, 0, 0, 3'b000);
                send(128'h53, 0, 1, 2, 1, 0, 1, 2, 3'b000);
                idle();
            end
            begin
                @(posedge clk); #1 out_if.rdy = 1'b1;
                @(posedge clk); #1 out_if.rdy = 1'b0;
                @(posedge clk); #1 out_if.rdy = 1'b0;
                @(posedge clk); #1 out_if.rdy = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset after beat 2 of 5, then an orphan and a clean single-beat packet
        send(128'h61, 1, 0, 0, 1, 1, 0, 0, 3'b000);
        send(128'h62, 0, 0, 0, 1, 0, 0, 0, 3'b000);
        idle();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        reset_checks("rst_mid");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(128'h63, 0, 0, 0, 0, 0, 0, 0, 3'b100);
        send(128'h64, 1, 1, 0, 1, 1, 1, 0, 3'b000);
        idle();

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
        chk("err_q_drained", 128'(err_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
